// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: shared definitions for the round-robin arbitrating mux.
//   - DefWidth / DefNumIn : default data width and channel count
//   - state_e             : output register occupancy (StEmpty / StFull)
//   - clog2 / sel_width   : constant functions for the channel-index width
package rr_arb_mux_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefNumIn = 4;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(n)) begin
            w++;
        end
        return w;
    endfunction

    // Channel index width; never narrower than one bit so NUM_IN=1 still has a port.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_mux_pick.sv
// rr_arb_mux_pick: combinational rotating priority picker.
//   req_i : per-channel request vector
//   ptr_i : highest-priority channel index (0..NUM_IN-1)
//   gnt_o : one-hot grant (all zero when no request)
//   idx_o : binary index of the granted channel
//   any_o : at least one request present
// The request vector is duplicated and shifted right by ptr_i, so the search
// order ptr, ptr+1, ..., wraps at NUM_IN rather than at a power of two.
module rr_arb_mux_pick #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic [NUM_IN-1:0] gnt_o,
    output logic [SEL_W-1:0]  idx_o,
    output logic              any_o
);

    localparam int unsigned SumW = SEL_W + 1;
    localparam logic [SumW-1:0] NumInW = SumW'(NUM_IN);

    logic [2*NUM_IN-1:0] dbl;
    logic [NUM_IN-1:0]   rot;
    logic [SEL_W-1:0]    off;
    logic [SumW-1:0]     sum;
    logic                found;

    always_comb begin
        dbl   = {req_i, req_i};
        rot   = NUM_IN'(dbl >> ptr_i);
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = SEL_W'(i);
            end
        end
        // ptr + offset is below 2*NUM_IN, so one conditional subtract wraps it.
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= NumInW) begin
            sum = sum - NumInW;
        end
        idx_o = sum[SEL_W-1:0];
        any_o = found;
        gnt_o = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            gnt_o[i] = found && (idx_o == SEL_W'(i));
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbitrating mux with a one-entry output register.
//   CLK, RST (async, active low)
//   IN_DATA/IN_VALID/IN_READY : per-channel valid/ready inputs, channel i at [i*WIDTH +: WIDTH]
//   OUT_DATA/OUT_VALID/OUT_READY/OUT_SEL : registered output word and its source channel
//   IN_LAST : end-of-packet marker, only when ARB_MUX_LOCK_EN is defined
// With ARB_MUX_LOCK_EN defined, a channel keeps the grant from its first word
// until the word carrying IN_LAST; the priority pointer moves only at that point.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned  WIDTH  = DefWidth,
    parameter int unsigned  NUM_IN = DefNumIn,
    localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
    input  logic [NUM_IN-1:0]       IN_VALID,
    output logic [NUM_IN-1:0]       IN_READY,
`ifdef ARB_MUX_LOCK_EN
    input  logic [NUM_IN-1:0]       IN_LAST,
`endif
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [SEL_W-1:0]        OUT_SEL
);

    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_IN - 1);

    state_e            state_q;
    logic [WIDTH-1:0]  out_data_q;
    logic [SEL_W-1:0]  out_sel_q;
    logic [SEL_W-1:0]  ptr_q;

    logic [NUM_IN-1:0] pick_gnt;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;

    logic [NUM_IN-1:0] gnt_vec;
    logic [SEL_W-1:0]  gnt_idx;
    logic              free;
    logic              xfer;
    logic [31:0]       base;
    logic [WIDTH-1:0]  sel_word;
    logic [SEL_W-1:0]  next_ptr;

`ifdef ARB_MUX_LOCK_EN
    logic              lock_q;
    logic [SEL_W-1:0]  lidx_q;
`endif

    rr_arb_mux_pick #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req_i (IN_VALID),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        gnt_vec = pick_gnt;
        gnt_idx = pick_idx;
`ifdef ARB_MUX_LOCK_EN
        // While locked only the owning channel can be granted, even if idle.
        if (lock_q) begin
            gnt_idx = lidx_q;
            for (int i = 0; i < NUM_IN; i++) begin
                gnt_vec[i] = (lidx_q == SEL_W'(i)) && IN_VALID[i];
            end
        end
`endif
        // Gating with RST keeps every IN_READY low while reset is held.
        free     = RST && ((state_q == StEmpty) || OUT_READY);
        IN_READY = free ? gnt_vec : '0;
        xfer     = free && (|gnt_vec);
        base     = 32'(gnt_idx) * 32'(WIDTH);
        sel_word = IN_DATA[base +: WIDTH];
        next_ptr = (gnt_idx == LastIdx) ? '0 : gnt_idx + SEL_W'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StEmpty;
            out_data_q <= '0;
            out_sel_q  <= '0;
            ptr_q      <= '0;
`ifdef ARB_MUX_LOCK_EN
            lock_q     <= 1'b0;
            lidx_q     <= '0;
`endif
        end else begin
            if (xfer) begin
                state_q    <= StFull;
                out_data_q <= sel_word;
                out_sel_q  <= gnt_idx;
`ifdef ARB_MUX_LOCK_EN
                if (IN_LAST[gnt_idx]) begin
                    lock_q <= 1'b0;
                    ptr_q  <= next_ptr;
                end else begin
                    lock_q <= 1'b1;
                    lidx_q <= gnt_idx;
                end
`else
                ptr_q      <= next_ptr;
`endif
            end else if (OUT_READY) begin
                // Drain without refill; data and index keep their last values.
                state_q <= StEmpty;
            end
        end
    end

    // pick_any is implied by |pick_gnt; kept on the picker for other users.
    logic unused_any;
    assign unused_any = pick_any;

    assign OUT_VALID = (state_q == StFull);
    assign OUT_DATA  = out_data_q;
    assign OUT_SEL   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [3:0]   in_last;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_sel;

    logic [23:0]  b_data;
    logic [2:0]   b_valid;
    logic [2:0]   b_ready;
    logic [2:0]   b_last;
    logic [7:0]   b_out;
    logic         b_ov;
    logic         b_or;
    logic [1:0]   b_sel;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(32), .NUM_IN(4)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
`ifdef ARB_MUX_LOCK_EN
        .IN_LAST   (in_last),
`endif
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_SEL   (out_sel)
    );

    rr_arb_mux #(.WIDTH(8), .NUM_IN(3)) dut3 (
        .CLK       (clk),
        .RST       (rst_n),
        .IN_DATA   (b_data),
        .IN_VALID  (b_valid),
        .IN_READY  (b_ready),
`ifdef ARB_MUX_LOCK_EN
        .IN_LAST   (b_last),
`endif
        .OUT_DATA  (b_out),
        .OUT_VALID (b_ov),
        .OUT_READY (b_or),
        .OUT_SEL   (b_sel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] v);
        in_data[ch*32 +: 32] = v;
    endtask

    initial begin
        logic [1:0]  t1_sel [5];
        logic [3:0]  t1_rdy [5];
        t1_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        t1_rdy = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_ch(i, 32'h1000_0000 + 32'(i));
        b_data  = {8'h33, 8'h22, 8'h11};
        b_valid = 3'b000;
        b_last  = 3'b111;
        b_or    = 1'b1;
        #2 rst_n = 1'b0;

        // Reset held: everything low even with all channels requesting.
        settle();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_sel", 32'(out_sel), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check("rst_hold_ready", 32'(in_ready), 32'd0);
        check("rst_hold_valid", 32'(out_valid), 32'd0);

        // Release: back-to-back rotation 0,1,2,3,0 with no bubble.
        #2 rst_n = 1'b1;
        settle();
        check("t1_ready0", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_sel", 32'(out_sel), 32'(t1_sel[k]));
            check("t1_data", out_data, 32'h1000_0000 + 32'(t1_sel[k]));
            check("t1_ready", 32'(in_ready), 32'(t1_rdy[k]));
        end

        // Backpressure: word from channel 1 held for 5 cycles.
        set_ch(1, 32'hA5A5_0001);
        tick();
        check("t3_load_data", out_data, 32'hA5A5_0001);
        check("t3_load_sel", 32'(out_sel), 32'd1);
        out_ready = 1'b0;
        settle();
        check("t3_bp_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_bp_data", out_data, 32'hA5A5_0001);
            check("t3_bp_sel", 32'(out_sel), 32'd1);
            check("t3_bp_valid", 32'(out_valid), 32'd1);
            check("t3_bp_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        settle();
        check("t3_rel_ready", 32'(in_ready), 32'b0100);
        tick();
        check("t3_refill_data", out_data, 32'h1000_0002);
        check("t3_refill_sel", 32'(out_sel), 32'd2);
        check("t3_refill_valid", 32'(out_valid), 32'd1);

        // Only channel 2 requesting (pointer now 3).
        in_valid = 4'b0100;
        set_ch(2, 32'h0000_0002);
        settle();
        check("t4_ready", 32'(in_ready), 32'b0100);
        tick();
        check("t4_data", out_data, 32'h0000_0002);
        check("t4_sel", 32'(out_sel), 32'd2);
        in_valid = 4'b1111;
        settle();
        check("t4_ptr3", 32'(in_ready), 32'b1000);
        tick();
        check("t4_sel3", 32'(out_sel), 32'd3);
        // No requests: drain, data/sel retained, pointer stays at 0.
        in_valid = 4'b0000;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data", out_data, 32'h1000_0003);
        check("drain_sel", 32'(out_sel), 32'd3);
        tick();
        in_valid = 4'b1010;
        settle();
        check("idle_ptr", 32'(in_ready), 32'b0010);

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        tick();
        check("t5_full", 32'(out_valid), 32'd1);
        check("t5_full_sel", 32'(out_sel), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_data", out_data, 32'd0);
        check("t5_async_ready", 32'(in_ready), 32'd0);
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        settle();
        check("t5_first_ready", 32'(in_ready), 32'b0001);
        tick();
        check("t5_first_sel", 32'(out_sel), 32'd0);
        check("t5_first_data", out_data, 32'h1000_0000);
        in_valid = 4'b0000;

        // Three channels: pointer wraps at 3, not 4.
        b_valid = 3'b010;
        settle();
        check("t2_ready1", 32'(b_ready), 32'b010);
        tick();
        check("t2_sel1", 32'(b_sel), 32'd1);
        check("t2_data1", 32'(b_out), 32'h22);
        b_valid = 3'b110;
        settle();
        check("t2_ready2", 32'(b_ready), 32'b100);
        tick();
        check("t2_sel2", 32'(b_sel), 32'd2);
        check("t2_data2", 32'(b_out), 32'h33);
        check("t2_wrap_ready", 32'(b_ready), 32'b010);
        tick();
        check("t2_wrap_sel", 32'(b_sel), 32'd1);
        b_valid = 3'b000;

`ifdef ARB_MUX_LOCK_EN
        // Packet lock: channel 1 keeps the grant for three words.
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        in_valid = 4'b0001;
        in_last  = 4'b0001;
        tick();
        check("t6_pre_sel", 32'(out_sel), 32'd0);
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        settle();
        check("t6_ready_w1", 32'(in_ready), 32'b0010);
        tick();
        check("t6_sel_w1", 32'(out_sel), 32'd1);
        check("t6_ready_w2", 32'(in_ready), 32'b0010);
        tick();
        check("t6_sel_w2", 32'(out_sel), 32'd1);
        in_valid = 4'b0001;
        settle();
        check("t6_idle_ready", 32'(in_ready), 32'b0000);
        tick();
        check("t6_idle_valid", 32'(out_valid), 32'd0);
        in_valid = 4'b0011;
        in_last  = 4'b0010;
        settle();
        check("t6_ready_w3", 32'(in_ready), 32'b0010);
        tick();
        check("t6_sel_w3", 32'(out_sel), 32'd1);
        check("t6_after_ready", 32'(in_ready), 32'b0001);
        tick();
        check("t6_after_sel", 32'(out_sel), 32'd0);
        in_valid = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
